mod12_count_sched: RTL and testbench

Controller and arbiter sharing one external mod-12 up/down counter among NREQ requesters. Each requester submits a command over a valid/ready handshake. A command is either LOAD (preset the counter) or RUN (count N steps up or down). The block arbitrates between requesters, drives the counter's load/enable/mode/data pins, waits one cycle for the counter to settle, then reports completion with the resulting count. It sits between the stimulus/host side and the mod-12 counter datapath.

---
 rtl/mod12_count_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_mod12_count_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod12_count_sched.sv
// Command scheduler sharing one external mod-12 up/down counter among NREQ requesters.
// Define MOD12_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module mod12_count_sched #(
  parameter int NREQ   = 2,
  parameter int STEP_W = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NREQ-1:0]                            req_valid,
  output logic [NREQ-1:0]                            req_ready,
  input  logic [NREQ-1:0]                            req_op,
  input  logic [NREQ-1:0]                            req_mode,
  input  logic [4*NREQ-1:0]                          req_data,
  input  logic [STEP_W*NREQ-1:0]                     req_steps,
  output logic                                       cnt_load,
  output logic                                       cnt_en,
  output logic                                       cnt_mode,
  output logic [3:0]                                 cnt_din,
  input  logic [3:0]                                 cnt_dout,
  output logic                                       busy,
  output logic                                       done_valid,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] done_id,
  output logic [3:0]                                 done_value,
  output logic                                       done_err
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_DONE} state_t;

  state_t              state_r, state_nx;
  logic [ID_W-1:0]     last_grant_r, last_grant_nx;
  logic                op_r, op_nx;
  logic                mode_r, mode_nx;
  logic [3:0]          data_r, data_nx;
  logic [STEP_W-1:0]   steps_left_r, steps_left_nx;
  logic [ID_W-1:0]     id_r, id_nx;

  logic                cnt_load_nx, cnt_en_nx, cnt_mode_nx;
  logic [3:0]          cnt_din_nx;
  logic                done_valid_nx, done_err_nx;
  logic [ID_W-1:0]     done_id_nx;
  logic [3:0]          done_value_nx;

  logic                found_s;
  logic [ID_W-1:0]     gnt_s, scan_id_s;
  logic                sel_op_s, sel_mode_s;
  logic [3:0]          sel_data_s;
  logic [STEP_W-1:0]   sel_steps_s;
  logic                accept_s;

  // Arbitration: first valid requester after last_grant (or lowest index in fixed mode).
  always_comb begin
    found_s   = 1'b0;
    gnt_s     = {ID_W{1'b0}};
    scan_id_s = {ID_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
`ifdef MOD12_SCHED_FIXED_PRIO_EN
      scan_id_s = ID_W'(k);
`else
      scan_id_s = ID_W'((int'(last_grant_r) + k + 1) % NREQ);
`endif
      if (!found_s && req_valid[scan_id_s]) begin
        found_s = 1'b1;
        gnt_s   = scan_id_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_op_s    = 1'b0;
    sel_mode_s  = 1'b0;
    sel_data_s  = 4'd0;
    sel_steps_s = {STEP_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_s == ID_W'(k)) begin
        sel_op_s    = req_op[k];
        sel_mode_s  = req_mode[k];
        sel_data_s  = req_data[4*k +: 4];
        sel_steps_s = req_steps[STEP_W*k +: STEP_W];
      end else begin
        sel_op_s    = sel_op_s;
      end
    end
  end

  assign accept_s = !reset && (state_r == ST_IDLE) && found_s;

  // Ready is the only combinational output, so an accept happens in the IDLE cycle itself.
  always_comb begin
    if (accept_s) begin
      req_ready = NREQ'(1'b1) << gnt_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next state plus next values of the registered outputs (outputs line up with the state they belong to).
  always_comb begin
    state_nx      = state_r;
    last_grant_nx = last_grant_r;
    op_nx         = op_r;
    mode_nx       = mode_r;
    data_nx       = data_r;
    steps_left_nx = steps_left_r;
    id_nx         = id_r;
    cnt_load_nx   = 1'b0;
    cnt_en_nx     = 1'b0;
    cnt_mode_nx   = 1'b0;
    cnt_din_nx    = 4'd0;
    done_valid_nx = 1'b0;
    done_id_nx    = done_id;
    done_value_nx = done_value;
    done_err_nx   = done_err;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nx      = ST_EXEC;
          last_grant_nx = gnt_s;
          op_nx         = sel_op_s;
          mode_nx       = sel_mode_s;
          data_nx       = sel_data_s;
          steps_left_nx = sel_steps_s;
          id_nx         = gnt_s;
          done_err_nx   = 1'b0;
          if (!sel_op_s && (sel_data_s <= 4'd11)) begin
            cnt_load_nx = 1'b1;
            cnt_din_nx  = sel_data_s;
          end else if (sel_op_s && (sel_steps_s != {STEP_W{1'b0}})) begin
            cnt_en_nx   = 1'b1;
            cnt_mode_nx = sel_mode_s;
          end else begin
            cnt_load_nx = 1'b0;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (!op_r) begin
          if (data_r <= 4'd11) begin
            state_nx = ST_WAIT;
          end else begin
            state_nx      = ST_DONE;
            done_valid_nx = 1'b1;
            done_id_nx    = id_r;
            done_value_nx = cnt_dout;
            done_err_nx   = 1'b1;
          end
        end else if (steps_left_r == {STEP_W{1'b0}}) begin
          state_nx      = ST_DONE;
          done_valid_nx = 1'b1;
          done_id_nx    = id_r;
          done_value_nx = cnt_dout;
        end else begin
          steps_left_nx = steps_left_r - STEP_W'(1'b1);
          if (steps_left_r == STEP_W'(1'b1)) begin
            state_nx = ST_WAIT;
          end else begin
            cnt_en_nx   = 1'b1;
            cnt_mode_nx = mode_r;
          end
        end
      end
      ST_WAIT: begin
        state_nx      = ST_DONE;
        done_valid_nx = 1'b1;
        done_id_nx    = id_r;
        done_value_nx = cnt_dout;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, command context and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= ID_W'(NREQ - 1);
      op_r         <= 1'b0;
      mode_r       <= 1'b0;
      data_r       <= 4'd0;
      steps_left_r <= {STEP_W{1'b0}};
      id_r         <= {ID_W{1'b0}};
      cnt_load     <= 1'b0;
      cnt_en       <= 1'b0;
      cnt_mode     <= 1'b0;
      cnt_din      <= 4'd0;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
      done_id      <= {ID_W{1'b0}};
      done_value   <= 4'd0;
      done_err     <= 1'b0;
    end else begin
      state_r      <= state_nx;
      last_grant_r <= last_grant_nx;
      op_r         <= op_nx;
      mode_r       <= mode_nx;
      data_r       <= data_nx;
      steps_left_r <= steps_left_nx;
      id_r         <= id_nx;
      cnt_load     <= cnt_load_nx;
      cnt_en       <= cnt_en_nx;
      cnt_mode     <= cnt_mode_nx;
      cnt_din      <= cnt_din_nx;
      busy         <= (state_nx != ST_IDLE);
      done_valid   <= done_valid_nx;
      done_id      <= done_id_nx;
      done_value   <= done_value_nx;
      done_err     <= done_err_nx;
    end
  end

endmodule

// File: tb/tb_mod12_count_sched.sv
// Directed testbench for mod12_count_sched with a behavioural mod-12 counter on the datapath side.
module tb_mod12_count_sched;

  localparam int NREQ   = 2;
  localparam int STEP_W = 8;
  localparam int DW     = 4 * NREQ;
  localparam int SW     = STEP_W * NREQ;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op = '0;
  logic [NREQ-1:0]   req_mode = '0;
  logic [DW-1:0]     req_data = '0;
  logic [SW-1:0]     req_steps = '0;
  logic              cnt_load, cnt_en, cnt_mode;
  logic [3:0]        cnt_din;
  logic [3:0]        cnt_dout;
  logic              busy, done_valid, done_err;
  logic [0:0]        done_id;
  logic [3:0]        done_value;
  logic [3:0]        cnt_q;

  int n_checks = 0;
  int n_errors = 0;

  mod12_count_sched #(.NREQ(NREQ), .STEP_W(STEP_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mode(req_mode),
    .req_data(req_data), .req_steps(req_steps),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_mode(cnt_mode), .cnt_din(cnt_din),
    .cnt_dout(cnt_dout), .busy(busy), .done_valid(done_valid), .done_id(done_id),
    .done_value(done_value), .done_err(done_err)
  );

  always #5 clock = ~clock;

  // External mod-12 up/down counter.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_din;
    else if (cnt_en) cnt_q <= cnt_mode ? ((cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1)
                                       : ((cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1);
    else cnt_q <= cnt_q;
  end
  assign cnt_dout = cnt_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input bit v, input bit op, input bit mode,
                         input int data, input int steps);
    logic [NREQ-1:0] m;
    logic [DW-1:0]   dm;
    logic [SW-1:0]   sm;
    m  = NREQ'(1) << id;
    dm = DW'(4'hF) << (4 * id);
    sm = SW'({STEP_W{1'b1}}) << (STEP_W * id);
    req_valid = v ? (req_valid | m) : (req_valid & ~m);
    req_op    = op ? (req_op | m) : (req_op & ~m);
    req_mode  = mode ? (req_mode | m) : (req_mode & ~m);
    req_data  = (req_data & ~dm) | (DW'(data[3:0]) << (4 * id));
    req_steps = (req_steps & ~sm) | (SW'(steps[STEP_W-1:0]) << (STEP_W * id));
  endtask

  // One command from a single requester, checking strobes, latency and completion fields.
  task automatic run_cmd(input int id, input bit op, input bit mode, input int data, input int steps,
                         input int exp_val, input int exp_err, input int exp_lat,
                         input int exp_en, input int exp_load);
    int lat, en_n, ld_n;
    bit got;
    @(negedge clock);
    set_req(id, 1'b1, op, mode, data, steps);
    #1 check("ready", 32'(req_ready), 32'(1 << id));
    @(negedge clock);
    set_req(id, 1'b0, op, mode, data, steps);
    check("busy", 32'(busy), 32'd1);
    lat = 1; en_n = 0; ld_n = 0; got = 1'b0;
    while (!got && lat < 400) begin
      if (cnt_en) begin
        en_n++;
        check("cnt_mode", 32'(cnt_mode), 32'(mode));
      end
      if (cnt_load) begin
        ld_n++;
        check("cnt_din", 32'(cnt_din), 32'(data));
      end
      if (cnt_en && cnt_load) check("load_en_excl", 32'd1, 32'd0);
      if (done_valid) got = 1'b1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("en_cycles", 32'(en_n), 32'(exp_en));
    check("load_cycles", 32'(ld_n), 32'(exp_load));
    check("done_id", 32'(done_id), 32'(id));
    check("done_value", 32'(done_value), 32'(exp_val));
    check("done_err", 32'(done_err), 32'(exp_err));
    @(negedge clock);
    check("done_pulse", 32'(done_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_g [4];
    int grants, dn, cyc;

    // Reset state, including no ready while reset is held.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 1'b0, 5, 0);
    #1 check("ready_in_reset", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clock);
    set_req(0, 1'b0, 1'b0, 1'b0, 5, 0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_cnt_load", 32'(cnt_load), 32'd0);
    check("rst_done_err", 32'(done_err), 32'd0);
    check("rst_done_value", 32'(done_value), 32'd0);
    reset = 1'b0;

    //      id op mode data steps  val err lat en load
    run_cmd(0, 0, 0,   5,   0,     5,  0,  3,  0, 1);
    run_cmd(1, 0, 0,   10,  0,     10, 0,  3,  0, 1);
    run_cmd(0, 1, 1,   0,   4,     2,  0,  6,  4, 0);
    run_cmd(1, 0, 0,   1,   0,     1,  0,  3,  0, 1);
    run_cmd(0, 1, 0,   0,   3,     10, 0,  5,  3, 0);
    run_cmd(1, 0, 0,   13,  0,     10, 1,  2,  0, 0);
    run_cmd(0, 1, 1,   0,   0,     10, 0,  2,  0, 0);

    // Arbitration with both requesters continuously valid, RUN up by 1 from a fresh counter.
`ifdef MOD12_SCHED_FIXED_PRIO_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b1, 0, 1);
    set_req(1, 1'b1, 1'b1, 1'b1, 0, 1);
    grants = 0; dn = 0; cyc = 0;
    while (grants < 4 && cyc < 200) begin
      #1;
      if (req_ready != 2'b00) begin
        check("grant", 32'(req_ready), 32'(exp_g[grants]));
        grants++;
      end
      if (done_valid) begin
        dn++;
        check("arb_value", 32'(done_value), 32'(dn));
      end
      @(negedge clock);
      cyc++;
    end
    check("grant_count", 32'(grants), 32'd4);
    set_req(0, 1'b0, 1'b1, 1'b1, 0, 1);
    set_req(1, 1'b0, 1'b1, 1'b1, 0, 1);
    repeat (10) @(negedge clock);

    // Long RUN aborted by reset.
    set_req(1, 1'b1, 1'b1, 1'b1, 0, 200);
    #1 check("long_ready", 32'(req_ready), 32'b10);
    @(negedge clock);
    set_req(1, 1'b0, 1'b1, 1'b1, 0, 200);
    repeat (49) @(negedge clock);
    check("en_before_reset", 32'(cnt_en), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_cnt_en", 32'(cnt_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done_valid), 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (250) begin
      @(negedge clock);
      if (done_valid) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);
    check("idle_cnt_en", 32'(cnt_en), 32'd0);
    set_req(0, 1'b1, 1'b1, 1'b1, 0, 0);
    set_req(1, 1'b1, 1'b1, 1'b1, 0, 0);
    #1 check("grant_after_reset", 32'(req_ready), 32'b01);
    @(negedge clock);
    req_valid = '0;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
